// File: rtl/axis_mux_scheduler.sv
// Packet-atomic round-robin select for a two-input AXI-stream mux.
// Select moves only between packets; each grant is capped at BURST_PKTS packets while the other input waits.
module axis_mux_scheduler #(
  parameter int BURST_PKTS = 4,
  parameter int CW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          axis0_tvalid,
  input  logic          axis1_tvalid,
  input  logic          out_tvalid,
  input  logic          out_tready,
  input  logic          out_tlast,
  input  logic          clear_counts,
  output logic          input_select,
  output logic          busy,
  output logic [CW-1:0] pkt_count0,
  output logic [CW-1:0] pkt_count1
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;
  localparam logic [8:0] BURST_LIM = 9'(BURST_PKTS);

  logic [0:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic [7:0]    burst_q, burst_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;

  logic       hs;
  logic       cur_v;
  logic       oth_v;
  logic       eop;
  logic [8:0] burst_inc;

  assign hs        = out_tvalid & out_tready;
  assign cur_v     = sel_q ? axis1_tvalid : axis0_tvalid;
  assign oth_v     = sel_q ? axis0_tvalid : axis1_tvalid;
  assign burst_inc = {1'b0, burst_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    burst_d = burst_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    eop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Any handshake here starts a packet on the already-registered select.
        if (hs) begin
          if (out_tlast) eop = 1'b1;
          else           state_d = ST_PKT;
        end else if (!cur_v && oth_v) begin
          sel_d   = ~sel_q;
          burst_d = '0;
        end
      end
      ST_PKT: begin
        if (hs && out_tlast) begin
          state_d = ST_IDLE;
          eop     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (eop) begin
      if (sel_q) cnt1_d = cnt1_q + CW'(1);
      else       cnt0_d = cnt0_q + CW'(1);
      if (burst_inc >= BURST_LIM && oth_v) begin
        sel_d   = ~sel_q;
        burst_d = '0;
      end else begin
        burst_d = (burst_inc >= BURST_LIM) ? BURST_LIM[7:0] : burst_inc[7:0];
      end
    end

    // Clear overrides a same-cycle increment.
    if (clear_counts) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      burst_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      burst_q <= burst_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign input_select = sel_q;
  assign busy         = (state_q == ST_PKT);
  assign pkt_count0   = cnt0_q;
  assign pkt_count1   = cnt1_q;

endmodule

// File: tb/tb_axis_mux_scheduler.sv
// Bench for axis_mux_scheduler: hand-derived vector table, reset/wrap sequences,
// and randomized packet traffic against a packet-level reference model.
module tb_axis_mux_scheduler;

  localparam int B  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic          ov = 1'b0, ordy = 1'b0, olast = 1'b0, clr = 1'b0;
  logic          sel, busy;
  logic [CW-1:0] c0, c1;

  int checks = 0;
  int errors = 0;

  axis_mux_scheduler #(.BURST_PKTS(B), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .axis0_tvalid (v0),
    .axis1_tvalid (v1),
    .out_tvalid   (ov),
    .out_tready   (ordy),
    .out_tlast    (olast),
    .clear_counts (clr),
    .input_select (sel),
    .busy         (busy),
    .pkt_count0   (c0),
    .pkt_count1   (c1)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {v0, v1, ov, ordy, olast, clr} = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Checking
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int esel, input int ebusy, input int ec0, input int ec1);
    chk({tag, ".sel"},  int'(sel),  esel);
    chk({tag, ".busy"}, int'(busy), ebusy);
    chk({tag, ".c0"},   int'(c0),   ec0);
    chk({tag, ".c1"},   int'(c1),   ec1);
  endtask

  // Driver: apply at negedge, sample 1 time unit after the following posedge
  task automatic drive_cycle(input logic a0, input logic a1, input logic aov, input logic ardy,
                             input logic alast, input logic aclr);
    @(negedge clk);
    {v0, v1, ov, ordy, olast, clr} = {a0, a1, aov, ardy, alast, aclr};
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v0, v1, ov, ordy, olast, clr;
    logic esel, ebusy;
    int   ec0, ec1;
  } vec_t;

  vec_t tbl[13];

  // Reference model: packet-level view of the grant
  int      m_sel, m_inpkt, m_grant;
  int      m_cnt[2];
  logic    exp_q[$];

  task automatic model_reset();
    m_sel = 0; m_inpkt = 0; m_grant = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic a0, input logic a1, input logic aov, input logic ardy,
                            input logic alast, input logic aclr);
    logic hsx, curv, othv, eopx;
    hsx  = aov & ardy;
    curv = (m_sel == 1) ? a1 : a0;
    othv = (m_sel == 1) ? a0 : a1;
    eopx = 1'b0;
    if (m_inpkt == 0) begin
      if (hsx) begin
        exp_q.push_back(m_sel[0]);
        if (alast) eopx = 1'b1;
        else       m_inpkt = 1;
      end else if (!curv && othv) begin
        m_sel = 1 - m_sel;
        m_grant = 0;
      end
    end else if (hsx && alast) begin
      m_inpkt = 0;
      eopx = 1'b1;
    end
    if (eopx) begin
      m_cnt[m_sel] = (m_cnt[m_sel] + 1) % (1 << CW);
      if (m_grant + 1 >= B && othv) begin
        m_sel = 1 - m_sel;
        m_grant = 0;
      end else begin
        m_grant = (m_grant + 1 > B) ? B : m_grant + 1;
      end
    end
    if (aclr) begin
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end
  endtask

  // Random traffic source state (one per mux input)
  logic pv[2];
  int   left[2];

  initial begin
    // Vector table: inputs for one cycle, outputs expected after that edge.
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0, 0,0}; // idle switch to 1
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1, 0,0}; // first beat
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1, 0,0};
    tbl[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0, 0,1}; // tlast
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0, 0,2}; // single-beat pkts
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0, 0,3};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0, 0,4}; // quota hit, toggle
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0, 0,0}; // clear beats increment
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0, 0,0};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1, 0,0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1, 0,0}; // tvalid drop keeps grant
    tbl[11] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0, 0,1};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0, 0,0};

    // Reset state
    do_reset();
    #1;
    chk_all("reset", 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive_cycle(tbl[i].v0, tbl[i].v1, tbl[i].ov, tbl[i].ordy, tbl[i].olast, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].esel), int'(tbl[i].ebusy), tbl[i].ec0, tbl[i].ec1);
    end

    // Counter wrap: 15 single-beat packets on input 0, then one more
    do_reset();
    for (int i = 0; i < 15; i++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("wrap15", 0, 0, 15, 0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("wrap0", 0, 0, 0, 0);

    // Reset asserted mid-packet with input 1 selected
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("pre_rst", 1, 1, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("post_rst_b0", 0, 1, 0, 0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("post_rst_b1", 0, 0, 1, 0);

    // Randomized packet traffic through an emulated mux
    do_reset();
    model_reset();
    pv[0] = 1'b0; pv[1] = 1'b0;
    left[0] = $urandom_range(1, 8);
    left[1] = $urandom_range(1, 8);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic s, a0, a1, aov, ardy, alast, aclr, hsx;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (!pv[k] && $urandom_range(0, 2) == 0) pv[k] = 1'b1;
      s     = sel;
      a0    = pv[0];
      a1    = pv[1];
      aov   = pv[s];
      alast = (left[s] == 1);
      ardy  = ($urandom_range(0, 3) != 0);
      aclr  = ($urandom_range(0, 99) == 0);
      hsx   = aov & ardy;
      {v0, v1, ov, ordy, olast, clr} = {a0, a1, aov, ardy, alast, aclr};
      model_step(a0, a1, aov, ardy, alast, aclr);
      // Every beat of a packet must be routed from the input that started it
      if (hsx) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("sb_src", int'(s), int'(exp_q[0]));
          if (alast) void'(exp_q.pop_front());
        end
        pv[s] = ($urandom_range(0, 1) == 1);
        left[s] = left[s] - 1;
        if (left[s] == 0) left[s] = $urandom_range(1, 8);
      end
      @(posedge clk);
      #1;
      chk_all("rand", m_sel, m_inpkt, m_cnt[0], m_cnt[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
